// File: rtl/mdu_pkg.sv
// ============================================================================
// Module  : mdu_pkg
// Brief   : Shared op encodings, FSM states and default width for mdu_hilo.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mdu_pkg;

    localparam int MDU_WIDTH = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PREP = 2'd1,
        S_CALC = 2'd2,
        S_FIX  = 2'd3
    } mdu_state_e;

endpackage

`default_nettype wire

// File: rtl/mdu_hilo_if.sv
// ============================================================================
// Module  : mdu_hilo_if
// Brief   : Operand/command and HI/LO result bundle for mdu_hilo.
//           div0 exists only when MDU_DIV0_FLAG_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface mdu_hilo_if
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
`ifdef MDU_DIV0_FLAG_EN
    logic             div0;
`endif

    modport master (
        output start, op, src_a, src_b, hi_we, lo_we, wdata,
`ifdef MDU_DIV0_FLAG_EN
        input  div0,
`endif
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, src_a, src_b, hi_we, lo_we, wdata,
`ifdef MDU_DIV0_FLAG_EN
        output div0,
`endif
        output busy, done, hi, lo
    );

endinterface

`default_nettype wire

// File: rtl/mdu_sign_fix.sv
// ============================================================================
// Module  : mdu_sign_fix
// Brief   : Combinational conditional two's-complement negate.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_sign_fix #(
    parameter int W = 64
) (
    input  logic [W-1:0] val_i,
    input  logic         neg_i,
    output logic [W-1:0] val_o
);

    assign val_o = neg_i ? -val_i : val_i;

endmodule

`default_nettype wire

// File: rtl/mdu_hilo.sv
// ============================================================================
// Module  : mdu_hilo
// Brief   : Iterative radix-2 multiply/divide unit with HI/LO registers.
//           Optional div0 flag output enabled by MDU_DIV0_FLAG_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_hilo
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic      clk,
    input  logic      reset,
    mdu_hilo_if.slave bus
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    mdu_state_e           state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [1:0]           op_q;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic [WIDTH-1:0]     opnd_q;
    logic [WIDTH-1:0]     hi_q;
    logic [WIDTH-1:0]     lo_q;
    logic                 sign_a_q;
    logic                 sign_b_q;
    logic                 zdiv_q;
    logic                 busy_q;
    logic                 done_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [2*WIDTH-1:0]   acc_d;
    logic [WIDTH-1:0]     hi_d;
    logic [WIDTH-1:0]     lo_d;

    logic                 w_is_signed;
    logic                 w_is_div;
    logic [WIDTH-1:0]     w_mag_a;
    logic [WIDTH-1:0]     w_mag_b;
    logic [WIDTH:0]       w_mul_sum;
    logic [WIDTH:0]       w_rem_sh;
    logic [WIDTH:0]       w_diff;
    logic [2*WIDTH-1:0]   w_res_in;
    logic [2*WIDTH-1:0]   w_res;
    logic [WIDTH-1:0]     w_rem_fix;

    assign w_is_signed = (op_q == OP_MULT) || (op_q == OP_DIV);
    assign w_is_div    = (op_q == OP_DIV)  || (op_q == OP_DIVU);

    mdu_sign_fix #(.W(WIDTH)) u_abs_a (
        .val_i (a_q),
        .neg_i (w_is_signed & a_q[WIDTH-1]),
        .val_o (w_mag_a)
    );

    mdu_sign_fix #(.W(WIDTH)) u_abs_b (
        .val_i (b_q),
        .neg_i (w_is_signed & b_q[WIDTH-1]),
        .val_o (w_mag_b)
    );

    // acc_q holds {partial product, multiplier} or {remainder, dividend/quotient}
    assign w_mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign w_rem_sh  = acc_q[2*WIDTH-1:WIDTH-1];
    assign w_diff    = w_rem_sh - {1'b0, opnd_q};

    always_comb begin
        acc_d = {w_mul_sum, acc_q[WIDTH-1:1]};
        if (w_is_div) begin
            if (w_diff[WIDTH]) begin
                acc_d = {w_rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end else begin
                acc_d = {w_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end
        end
    end

    assign w_res_in = w_is_div ? {{WIDTH{1'b0}}, acc_q[WIDTH-1:0]} : acc_q;

    mdu_sign_fix #(.W(2*WIDTH)) u_res (
        .val_i (w_res_in),
        .neg_i (w_is_signed & (sign_a_q ^ sign_b_q)),
        .val_o (w_res)
    );

    // Remainder takes the dividend's sign, independent of the quotient
    mdu_sign_fix #(.W(WIDTH)) u_rem (
        .val_i (acc_q[2*WIDTH-1:WIDTH]),
        .neg_i (w_is_signed & sign_a_q),
        .val_o (w_rem_fix)
    );

    always_comb begin
        hi_d = w_res[2*WIDTH-1:WIDTH];
        lo_d = w_res[WIDTH-1:0];
        if (w_is_div) begin
            hi_d = zdiv_q ? a_q : w_rem_fix;
            lo_d = zdiv_q ? '1  : w_res[WIDTH-1:0];
        end
    end

`ifdef MDU_DIV0_FLAG_EN
    logic div0_q;
    assign bus.div0 = div0_q;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            opnd_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            zdiv_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            acc_q    <= '0;
`ifdef MDU_DIV0_FLAG_EN
            div0_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
`ifdef MDU_DIV0_FLAG_EN
            div0_q <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (bus.hi_we) hi_q <= bus.wdata;
                    if (bus.lo_we) lo_q <= bus.wdata;
                    if (bus.start) begin
                        op_q    <= bus.op;
                        a_q     <= bus.src_a;
                        b_q     <= bus.src_b;
                        busy_q  <= 1'b1;
                        state_q <= S_PREP;
                    end
                end
                S_PREP: begin
                    sign_a_q <= w_is_signed & a_q[WIDTH-1];
                    sign_b_q <= w_is_signed & b_q[WIDTH-1];
                    zdiv_q   <= (b_q == '0);
                    acc_q    <= {{WIDTH{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
                    opnd_q   <= w_is_div ? w_mag_b : w_mag_a;
                    cnt_q    <= '0;
                    state_q  <= S_CALC;
                end
                S_CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) state_q <= S_FIX;
                end
                S_FIX: begin
                    hi_q    <= hi_d;
                    lo_q    <= lo_d;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
`ifdef MDU_DIV0_FLAG_EN
                    div0_q  <= w_is_div & zdiv_q;
`endif
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

`default_nettype wire
